// File: rtl/sik_pkg.sv
// Shared definitions for the SIK stack processor: op encodings and datapath width.
package sik_pkg;

   localparam int unsigned WORD = 16;

   localparam logic [2:0] OpNop   = 3'd0;
   localparam logic [2:0] OpPush  = 3'd1;
   localparam logic [2:0] OpPop   = 3'd2;
   localparam logic [2:0] OpGet   = 3'd3;
   localparam logic [2:0] OpPut   = 3'd4;
   localparam logic [2:0] OpPeek2 = 3'd5;
   localparam logic [2:0] OpBinwb = 3'd6;

   // Source of the primary response word.
   localparam logic [1:0] ASelZero = 2'd0;
   localparam logic [1:0] ASelMem  = 2'd1;
   localparam logic [1:0] ASelData = 2'd2;

endpackage

// File: rtl/stack_addr_check.sv
// Decodes one stack op against the current depth: slots to read/write, new depth, legality.
module stack_addr_check
   import sik_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned ARGW  = 4,
   parameter int unsigned CW    = $clog2(DEPTH + 1),
   parameter int unsigned SW    = $clog2(DEPTH)
) (
   input  logic [CW-1:0]   c,
   input  logic [2:0]      op_code,
   input  logic [ARGW-1:0] op_arg,
   output logic [SW-1:0]   rd_a,
   output logic [SW-1:0]   rd_b,
   output logic [SW-1:0]   wr_slot,
   output logic            wr_en,
   output logic            wr_from_mem,
   output logic [1:0]      a_sel,
   output logic            b_en,
   output logic [CW-1:0]   new_cnt,
   output logic            err
);

   // One bit wider than either operand so c-1-k and c+1 can never wrap.
   localparam int unsigned XW = ((CW > ARGW) ? CW : ARGW) + 1;
   localparam logic [XW-1:0] One = XW'(1);
   localparam logic [XW-1:0] Two = XW'(2);
   localparam logic [XW-1:0] Dx  = XW'(DEPTH);

   logic [XW-1:0] cx, kx, nx;
   logic          ok;

   assign cx = XW'(c);
   assign kx = XW'(op_arg);

   always_comb begin
      ok          = 1'b1;
      wr_en       = 1'b0;
      wr_from_mem = 1'b0;
      a_sel       = ASelZero;
      b_en        = 1'b0;
      nx          = cx;
      rd_a        = SW'(cx - One);
      rd_b        = SW'(cx - Two);
      wr_slot     = SW'(cx);
      case (op_code)
         OpPush: begin
            ok    = cx < Dx;
            wr_en = 1'b1;
            a_sel = ASelData;
            nx    = cx + One;
         end
         OpPop: begin
            ok    = kx <= cx;
            a_sel = (cx == '0) ? ASelZero : ASelMem;
            nx    = cx - kx;
         end
         OpGet: begin
            ok          = (kx < cx) && (cx < Dx);
            rd_a        = SW'(cx - One - kx);
            wr_en       = 1'b1;
            wr_from_mem = 1'b1;
            a_sel       = ASelMem;
            nx          = cx + One;
         end
         OpPut: begin
            ok          = kx < cx;
            wr_slot     = SW'(cx - One - kx);
            wr_en       = 1'b1;
            wr_from_mem = 1'b1;
            a_sel       = ASelMem;
         end
         OpPeek2: begin
            ok    = cx >= Two;
            a_sel = ASelMem;
            b_en  = 1'b1;
         end
         OpBinwb: begin
            ok      = cx >= Two;
            wr_slot = SW'(cx - Two);
            wr_en   = 1'b1;
            a_sel   = ASelData;
            nx      = cx - One;
         end
         default: ;
      endcase
      err = ~ok;
      if (err) begin
         wr_en = 1'b0;
         a_sel = ASelZero;
         b_en  = 1'b0;
         nx    = cx;
      end
      new_cnt = CW'(nx);
   end

endmodule

// File: rtl/mt_stack_file.sv
// Multi-thread operand stack storage: one op per cycle, registered response one cycle later.
module mt_stack_file
   import sik_pkg::*;
#(
   parameter int unsigned WIDTH    = WORD,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned NTHREADS = 2,
   parameter int unsigned ARGW     = 4,
   localparam int unsigned TW      = (NTHREADS > 1) ? $clog2(NTHREADS) : 1,
   localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   op_valid,
   input  logic [TW-1:0]          op_thread,
   input  logic [2:0]             op_code,
   input  logic [ARGW-1:0]        op_arg,
   input  logic [WIDTH-1:0]       op_data,
   input  logic [NTHREADS-1:0]    clr,
   output logic                   rsp_valid,
   output logic [TW-1:0]          rsp_thread,
   output logic [WIDTH-1:0]       rsp_a,
   output logic [WIDTH-1:0]       rsp_b,
   output logic                   rsp_err,
   output logic [NTHREADS*CW-1:0] cnt,
   output logic [NTHREADS-1:0]    empty,
   output logic [NTHREADS-1:0]    full
);

   localparam int unsigned SW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [NTHREADS][DEPTH];
   logic [CW-1:0]    cnt_q [NTHREADS];

   logic             thread_ok, collide, accept;
   logic [CW-1:0]    cur_cnt, new_cnt;
   logic [SW-1:0]    rd_a, rd_b, wr_slot;
   logic             wr_en, wr_from_mem, b_en, chk_err;
   logic [1:0]       a_sel;
   logic [WIDTH-1:0] rd_a_data, rd_b_data, wr_data, a_val;

   logic             rsp_valid_q, rsp_err_q;
   logic [TW-1:0]    rsp_thread_q;
   logic [WIDTH-1:0] rsp_a_q, rsp_b_q;

   assign thread_ok = 32'(op_thread) < NTHREADS;
   assign cur_cnt   = thread_ok ? cnt_q[op_thread] : '0;
   assign collide   = thread_ok & clr[op_thread];

   stack_addr_check #(
      .DEPTH (DEPTH),
      .ARGW  (ARGW),
      .CW    (CW),
      .SW    (SW)
   ) u_check (
      .c           (cur_cnt),
      .op_code     (op_code),
      .op_arg      (op_arg),
      .rd_a        (rd_a),
      .rd_b        (rd_b),
      .wr_slot     (wr_slot),
      .wr_en       (wr_en),
      .wr_from_mem (wr_from_mem),
      .a_sel       (a_sel),
      .b_en        (b_en),
      .new_cnt     (new_cnt),
      .err         (chk_err)
   );

   // A clear on the op's own thread discards the op.
   assign accept    = op_valid & thread_ok & ~collide & ~chk_err;
   assign rd_a_data = mem[op_thread][rd_a];
   assign rd_b_data = mem[op_thread][rd_b];
   assign wr_data   = wr_from_mem ? rd_a_data : op_data;

   always_comb begin
      case (a_sel)
         ASelMem:  a_val = rd_a_data;
         ASelData: a_val = op_data;
         default:  a_val = '0;
      endcase
   end

   // Array contents are not reset.
   always_ff @(posedge clk) begin
      if (accept && wr_en) mem[op_thread][wr_slot] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned t = 0; t < NTHREADS; t++) cnt_q[t] <= '0;
      end else begin
         for (int unsigned t = 0; t < NTHREADS; t++) begin
            if (clr[t]) begin
               cnt_q[t] <= '0;
            end else if (accept && (32'(op_thread) == t)) begin
               cnt_q[t] <= new_cnt;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid_q  <= 1'b0;
         rsp_thread_q <= '0;
         rsp_err_q    <= 1'b0;
         rsp_a_q      <= '0;
         rsp_b_q      <= '0;
      end else begin
         rsp_valid_q  <= op_valid;
         rsp_thread_q <= op_valid ? op_thread : '0;
         rsp_err_q    <= op_valid & ~accept;
         rsp_a_q      <= accept ? a_val : '0;
         rsp_b_q      <= (accept && b_en) ? rd_b_data : '0;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_thread = rsp_thread_q;
   assign rsp_err    = rsp_err_q;
   assign rsp_a      = rsp_a_q;
   assign rsp_b      = rsp_b_q;

   always_comb begin
      cnt   = '0;
      empty = '0;
      full  = '0;
      for (int unsigned t = 0; t < NTHREADS; t++) begin
         cnt[t*CW +: CW] = cnt_q[t];
         empty[t]        = (cnt_q[t] == '0);
         full[t]         = (cnt_q[t] == CW'(DEPTH));
      end
   end

endmodule

// File: tb/tb_mt_stack_file.sv
// Directed bench for mt_stack_file with hand-computed expectations per scenario.
module tb_mt_stack_file;
   import sik_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [0:0]  op_thread;
   logic [2:0]  op_code;
   logic [3:0]  op_arg;
   logic [15:0] op_data;
   logic [1:0]  clr;
   logic        rsp_valid;
   logic [0:0]  rsp_thread;
   logic [15:0] rsp_a, rsp_b;
   logic        rsp_err;
   logic [9:0]  cnt;
   logic [1:0]  empty, full;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mt_stack_file #(
      .WIDTH    (16),
      .DEPTH    (16),
      .NTHREADS (2),
      .ARGW     (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .op_valid   (op_valid),
      .op_thread  (op_thread),
      .op_code    (op_code),
      .op_arg     (op_arg),
      .op_data    (op_data),
      .clr        (clr),
      .rsp_valid  (rsp_valid),
      .rsp_thread (rsp_thread),
      .rsp_a      (rsp_a),
      .rsp_b      (rsp_b),
      .rsp_err    (rsp_err),
      .cnt        (cnt),
      .empty      (empty),
      .full       (full)
   );

   // Drive one cycle of stimulus, return 1 time unit after the edge so its response is visible.
   task automatic issue(input logic v, input logic thr, input logic [2:0] code,
                        input logic [3:0] arg, input logic [15:0] data, input logic [1:0] c);
      op_valid  = v;
      op_thread = thr;
      op_code   = code;
      op_arg    = arg;
      op_data   = data;
      clr       = c;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      op_code  = OpNop;
      op_arg   = '0;
      op_data  = '0;
      clr      = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      op_valid = 1'b0; op_thread = '0; op_code = OpNop; op_arg = '0; op_data = '0; clr = '0;
      #12;
      n_cmp++; if (cnt !== 10'd0) begin n_bad++; $display("FAIL reset_cnt got %h want 0", cnt); end
      n_cmp++; if (empty !== 2'b11) begin n_bad++; $display("FAIL reset_empty got %b want 11", empty); end
      n_cmp++; if (full !== 2'b00) begin n_bad++; $display("FAIL reset_full got %b want 00", full); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_depth_fill();
      for (int i = 1; i <= 16; i++) begin
         issue(1'b1, 1'b0, OpPush, 4'd0, 16'(i), 2'b00);
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_a !== 16'(i)) begin
            n_bad++;
            $display("FAIL fill_push[%0d] got v=%b e=%b a=%h want v=1 e=0 a=%h",
                     i, rsp_valid, rsp_err, rsp_a, 16'(i));
         end
      end
      n_cmp++; if (cnt[4:0] !== 5'd16) begin n_bad++; $display("FAIL fill_cnt got %0d want 16", cnt[4:0]); end
      n_cmp++; if (full !== 2'b01) begin n_bad++; $display("FAIL fill_full got %b want 01", full); end
      issue(1'b1, 1'b0, OpPush, 4'd0, 16'h0011, 2'b00);
      n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL overflow_err got %b want 1", rsp_err); end
      n_cmp++; if (rsp_a !== 16'h0) begin n_bad++; $display("FAIL overflow_a got %h want 0", rsp_a); end
      n_cmp++; if (cnt[4:0] !== 5'd16) begin n_bad++; $display("FAIL overflow_cnt got %0d want 16", cnt[4:0]); end
      issue(1'b0, 1'b0, OpNop, 4'd0, 16'h0, 2'b01);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid got %b want 0", rsp_valid); end
      n_cmp++; if (cnt[4:0] !== 5'd0) begin n_bad++; $display("FAIL clr_cnt got %0d want 0", cnt[4:0]); end
      n_cmp++; if (empty !== 2'b11) begin n_bad++; $display("FAIL clr_empty got %b want 11", empty); end
   endtask

   task automatic test_stack_ops();
      issue(1'b1, 1'b1, OpPush, 4'd0, 16'd5, 2'b00);
      issue(1'b1, 1'b1, OpPush, 4'd0, 16'd7, 2'b00);
      issue(1'b1, 1'b1, OpPush, 4'd0, 16'd9, 2'b00);
      n_cmp++; if (cnt[9:5] !== 5'd3) begin n_bad++; $display("FAIL t1_push_cnt got %0d want 3", cnt[9:5]); end
      issue(1'b1, 1'b1, OpGet, 4'd2, 16'h0, 2'b00);
      n_cmp++; if (rsp_a !== 16'd5) begin n_bad++; $display("FAIL get2_a got %h want 5", rsp_a); end
      n_cmp++; if (cnt[9:5] !== 5'd4) begin n_bad++; $display("FAIL get2_cnt got %0d want 4", cnt[9:5]); end
      n_cmp++; if (rsp_thread !== 1'b1) begin n_bad++; $display("FAIL get2_thr got %b want 1", rsp_thread); end
      issue(1'b1, 1'b1, OpPut, 4'd3, 16'h0, 2'b00);
      n_cmp++; if (rsp_a !== 16'd5 || rsp_err !== 1'b0) begin
         n_bad++; $display("FAIL put3 got a=%h e=%b want a=5 e=0", rsp_a, rsp_err);
      end
      issue(1'b1, 1'b1, OpPeek2, 4'd0, 16'h0, 2'b00);
      n_cmp++; if (rsp_a !== 16'd5) begin n_bad++; $display("FAIL peek_a got %h want 5", rsp_a); end
      n_cmp++; if (rsp_b !== 16'd9) begin n_bad++; $display("FAIL peek_b got %h want 9", rsp_b); end
      issue(1'b1, 1'b1, OpPop, 4'd5, 16'h0, 2'b00);
      n_cmp++; if (rsp_err !== 1'b1 || cnt[9:5] !== 5'd4) begin
         n_bad++; $display("FAIL pop5_underflow got e=%b cnt=%0d want e=1 cnt=4", rsp_err, cnt[9:5]);
      end
      issue(1'b1, 1'b1, OpGet, 4'd4, 16'h0, 2'b00);
      n_cmp++; if (rsp_err !== 1'b1 || cnt[9:5] !== 5'd4) begin
         n_bad++; $display("FAIL get4_range got e=%b cnt=%0d want e=1 cnt=4", rsp_err, cnt[9:5]);
      end
      issue(1'b1, 1'b1, OpPop, 4'd3, 16'h0, 2'b00);
      n_cmp++; if (rsp_a !== 16'd5 || cnt[9:5] !== 5'd1) begin
         n_bad++; $display("FAIL pop3 got a=%h cnt=%0d want a=5 cnt=1", rsp_a, cnt[9:5]);
      end
      // Remaining slot 0 was overwritten by PUT 3.
      issue(1'b1, 1'b1, OpPop, 4'd1, 16'h0, 2'b00);
      n_cmp++; if (rsp_a !== 16'd5 || cnt[9:5] !== 5'd0) begin
         n_bad++; $display("FAIL pop_slot0 got a=%h cnt=%0d want a=5 cnt=0", rsp_a, cnt[9:5]);
      end
      issue(1'b1, 1'b1, OpPop, 4'd0, 16'h0, 2'b00);
      n_cmp++; if (rsp_err !== 1'b0 || rsp_a !== 16'h0) begin
         n_bad++; $display("FAIL pop0_empty got e=%b a=%h want e=0 a=0", rsp_err, rsp_a);
      end
      issue(1'b1, 1'b1, OpPop, 4'd1, 16'h0, 2'b00);
      n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL pop1_empty got e=%b want 1", rsp_err); end
   endtask

   task automatic test_binwb();
      issue(1'b1, 1'b0, OpPush, 4'd0, 16'd3, 2'b00);
      issue(1'b1, 1'b0, OpPush, 4'd0, 16'd4, 2'b00);
      issue(1'b1, 1'b0, OpPeek2, 4'd0, 16'h0, 2'b00);
      n_cmp++; if (rsp_a !== 16'd4 || rsp_b !== 16'd3) begin
         n_bad++; $display("FAIL bin_peek got a=%h b=%h want a=4 b=3", rsp_a, rsp_b);
      end
      issue(1'b1, 1'b0, OpBinwb, 4'd0, 16'd7, 2'b00);
      n_cmp++; if (rsp_a !== 16'd7 || cnt[4:0] !== 5'd1) begin
         n_bad++; $display("FAIL binwb got a=%h cnt=%0d want a=7 cnt=1", rsp_a, cnt[4:0]);
      end
      issue(1'b1, 1'b0, OpPeek2, 4'd0, 16'h0, 2'b00);
      n_cmp++; if (rsp_err !== 1'b1 || rsp_a !== 16'h0 || rsp_b !== 16'h0) begin
         n_bad++; $display("FAIL peek_short got e=%b a=%h b=%h want e=1 a=0 b=0", rsp_err, rsp_a, rsp_b);
      end
      issue(1'b1, 1'b0, OpPop, 4'd1, 16'h0, 2'b00);
      n_cmp++; if (rsp_a !== 16'd7 || cnt[4:0] !== 5'd0) begin
         n_bad++; $display("FAIL binwb_slot got a=%h cnt=%0d want a=7 cnt=0", rsp_a, cnt[4:0]);
      end
      issue(1'b1, 1'b0, 3'd7, 4'd0, 16'hFFFF, 2'b00);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_a !== 16'h0) begin
         n_bad++; $display("FAIL reserved_op got v=%b e=%b a=%h want v=1 e=0 a=0", rsp_valid, rsp_err, rsp_a);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         issue(1'b1, 1'b0, OpPush, 4'd0, 16'hA000 + 16'(i), 2'b00);
         issue(1'b1, 1'b1, OpPush, 4'd0, 16'hB000 + 16'(i), 2'b00);
         n_cmp++; if (rsp_thread !== 1'b1 || rsp_a !== 16'hB000 + 16'(i)) begin
            n_bad++; $display("FAIL ilv_push[%0d] got thr=%b a=%h", i, rsp_thread, rsp_a);
         end
      end
      issue(1'b1, 1'b0, OpPop, 4'd1, 16'h0, 2'b00);
      n_cmp++; if (rsp_a !== 16'hA007 || rsp_thread !== 1'b0) begin
         n_bad++; $display("FAIL ilv_pop0 got a=%h thr=%b want a=a007 thr=0", rsp_a, rsp_thread);
      end
      issue(1'b1, 1'b1, OpPop, 4'd1, 16'h0, 2'b00);
      n_cmp++; if (rsp_a !== 16'hB007 || rsp_thread !== 1'b1) begin
         n_bad++; $display("FAIL ilv_pop1 got a=%h thr=%b want a=b007 thr=1", rsp_a, rsp_thread);
      end
      n_cmp++; if (cnt !== {5'd7, 5'd7}) begin n_bad++; $display("FAIL ilv_cnt got %h want 0e7", cnt); end
   endtask

   task automatic test_clear_collision();
      issue(1'b1, 1'b0, OpPush, 4'd0, 16'hDEAD, 2'b01);
      n_cmp++; if (rsp_err !== 1'b1 || rsp_a !== 16'h0) begin
         n_bad++; $display("FAIL clr_coll got e=%b a=%h want e=1 a=0", rsp_err, rsp_a);
      end
      n_cmp++; if (cnt !== {5'd7, 5'd0}) begin n_bad++; $display("FAIL clr_coll_cnt got %h want 0e0", cnt); end
      issue(1'b1, 1'b1, OpPush, 4'd0, 16'hCCCC, 2'b01);
      n_cmp++; if (rsp_err !== 1'b0 || rsp_a !== 16'hCCCC) begin
         n_bad++; $display("FAIL clr_other got e=%b a=%h want e=0 a=cccc", rsp_err, rsp_a);
      end
      n_cmp++; if (cnt !== {5'd8, 5'd0}) begin n_bad++; $display("FAIL clr_other_cnt got %h want 100", cnt); end
      issue(1'b1, 1'b1, OpPop, 4'd1, 16'h0, 2'b00);
      n_cmp++; if (rsp_a !== 16'hCCCC || cnt[9:5] !== 5'd7) begin
         n_bad++; $display("FAIL clr_other_pop got a=%h cnt=%0d want a=cccc cnt=7", rsp_a, cnt[9:5]);
      end
   endtask

   task automatic test_async_reset();
      issue(1'b1, 1'b1, OpPush, 4'd0, 16'h1234, 2'b00);
      n_cmp++; if (rsp_valid !== 1'b1 || cnt[9:5] !== 5'd8) begin
         n_bad++; $display("FAIL pre_reset got v=%b cnt=%0d want v=1 cnt=8", rsp_valid, cnt[9:5]);
      end
      op_valid = 1'b1; op_thread = 1'b0; op_code = OpPush; op_data = 16'h5555;
      #2;
      reset = 1'b0;
      #1;
      n_cmp++; if (rsp_valid !== 1'b0 || rsp_a !== 16'h0) begin
         n_bad++; $display("FAIL async_rsp got v=%b a=%h want v=0 a=0", rsp_valid, rsp_a);
      end
      n_cmp++; if (cnt !== 10'd0 || empty !== 2'b11) begin
         n_bad++; $display("FAIL async_cnt got cnt=%h empty=%b want 0 11", cnt, empty);
      end
      @(posedge clk);
      #1;
      n_cmp++; if (rsp_valid !== 1'b0 || cnt !== 10'd0) begin
         n_bad++; $display("FAIL reset_hold got v=%b cnt=%h want v=0 cnt=0", rsp_valid, cnt);
      end
      op_valid = 1'b0; op_code = OpNop; op_data = '0;
      reset = 1'b1;
      issue(1'b1, 1'b0, OpPush, 4'd0, 16'h0055, 2'b00);
      n_cmp++; if (rsp_a !== 16'h0055 || cnt[4:0] !== 5'd1) begin
         n_bad++; $display("FAIL post_reset got a=%h cnt=%0d want a=0055 cnt=1", rsp_a, cnt[4:0]);
      end
   endtask

   initial begin
      test_reset();
      test_depth_fill();
      test_stack_ops();
      test_binwb();
      test_back_to_back();
      test_clear_collision();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mt_stack_file.md
# mt_stack_file

Parametrised multi-thread operand-stack storage for the SIK stack processor. Holds NTHREADS independent stacks of DEPTH words each, with a per-thread depth counter. It executes one stack operation per cycle (push, pop-n, get-k, put-k, peek-two, binary write-back) and returns registered read data with a one-cycle latency. It sits between the decode stage and the ALU/write stage. It replaces the single-thread regfile/stack-pointer logic and adds overflow/underflow detection and per-thread clear.

## Interface
- WIDTH, 16: stack word width.
- DEPTH, 16: words per thread stack (≥2).
- NTHREADS, 2: number of thread contexts (≥1).
- ARGW, 4: width of the k/n argument.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation present this cycle.
- op_thread  in  TW=max(1,$clog2(NTHREADS))  target thread.
- op_code  in  3  operation, encoded in sik_pkg.
- op_arg  in  ARGW  k (GET/PUT) or n (POP).
- op_data  in  WIDTH  push/write-back value.
- clr  in  NTHREADS  per-thread synchronous clear of the depth counter.
- rsp_valid  out  1  response for the operation accepted the previous cycle.
- rsp_thread  out  TW  thread of the response.
- rsp_a  out  WIDTH  primary read value.
- rsp_b  out  WIDTH  secondary read value.
- rsp_err  out  1  operation rejected (overflow/underflow/clear collision).
- cnt  out  NTHREADS*CW, CW=$clog2(DEPTH+1)  per-thread depth, thread t at [t*CW +: CW].
- empty, full  out  NTHREADS each  cnt==0 / cnt==DEPTH per thread.

## Operation
- Storage is a register array of NTHREADS×DEPTH words. Reads are combinational from the array; writes occur at the clock edge.
- c = cnt[op_thread]. Top of stack is slot c-1. Slot index s(k) = c-1-k.
- NOP: no state change. rsp_a = rsp_b = 0.
- PUSH: requires c<DEPTH. mem[c] ← op_data, cnt ← c+1. rsp_a = op_data.
- POP n: requires n≤c. cnt ← c-n. rsp_a = mem[c-1] (0 if c==0). POP 0 is a legal no-op.
- GET k: requires k<c and c<DEPTH. mem[c] ← mem[s(k)], cnt ← c+1. rsp_a = copied value. DUP is GET 0.
- PUT k: requires k<c. mem[s(k)] ← mem[c-1], cnt unchanged. rsp_a = written value.
- PEEK2: requires c≥2. rsp_a = mem[c-1], rsp_b = mem[c-2]. No state change.
- BINWB: requires c≥2. mem[c-2] ← op_data, cnt ← c-1. rsp_a = op_data. Used after PEEK2 once the ALU result is ready.
- A violated requirement gives rsp_err=1, rsp_a = rsp_b = 0, and no write or cnt change.
- clr[t] sets cnt[t] to 0 at the edge. Array contents are not cleared.
- clr[t] in the same cycle as an op on thread t: clear wins, the op is discarded, and its response has rsp_err=1.
- Ops on other threads proceed normally alongside a clear.
- Threads are fully isolated. No op touches another thread's slots.
- All index arithmetic is done at CW+1 bits, so no wrap-around is possible. Out-of-range requests are rejected, never wrapped.

## Timing
- Throughput: one op per cycle, back-to-back on the same or different threads. There is no ready/stall signal.
- Latency: an op with op_valid high at edge N produces rsp_* at edge N+1, valid for exactly one cycle.
- Writes and cnt updates from edge N are visible to the op at edge N+1. No bypass is needed because reads come from the array.
- rsp_valid=0 in any cycle following op_valid=0. rsp_a, rsp_b and rsp_err hold 0 when rsp_valid=0.
- Reset (asynchronous, active-low) clears:
  - all cnt to 0, so empty is all ones and full is all zeros;
  - rsp_valid, rsp_err, rsp_a, rsp_b and rsp_thread to 0.
- Array contents are undefined after reset.
- Reset asserted mid-stream drops any in-flight response immediately.

## Structure
- Shared package sik_pkg holds the op_code localparams (NOP=0, PUSH=1, POP=2, GET=3, PUT=4, PEEK2=5, BINWB=6; 7 is reserved and treated as NOP) and the WORD width constant.
- One sub-module is natural: stack_addr_check. It is combinational: given c, op_code and op_arg, it produces the read/write slots, the new cnt and the error flag, instantiated once for the selected thread.

## Test plan
- Depth fill: after reset, PUSH 1..16 on thread 0. cnt[0]=16, full[0]=1. A 17th PUSH gives rsp_err=1 and cnt stays at 16.
- Stack ops: PUSH 5, 7, 9 on thread 1, then:
  - GET 2 → rsp_a=5, cnt=4;
  - PUT 3 → slot 0 ← 5;
  - PEEK2 → rsp_a=5, rsp_b=9.
- Binary write-back: with [3,4] on thread 0, PEEK2 → rsp_a=4, rsp_b=3. Then BINWB 7 → cnt=1, and PEEK2 → rsp_err=1.
- Interleave: alternate PUSH to thread 0 (0xA000+i) and thread 1 (0xB000+i) 8 times, then POP 1 each. rsp_a=0xA007 and 0xB007, cnt=7 each.
- Clear collision: clr=2'b01 together with PUSH on thread 0 → rsp_err=1, cnt[0]=0. The same cycle's op on thread 1 succeeds.
- Async reset: assert reset low between edges mid-stream. cnt and rsp_valid go to 0 immediately, with no response on the next edge.
